// File: rtl/speed_sample_scheduler.sv
// speed_sample_scheduler: periodic coherent angle capture with round-robin delta streaming
module speed_sample_scheduler #(
    parameter int N_CH = 4,
    parameter int PERIOD_W = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PERIOD_W-1:0]     period,
    input  logic [N_CH*32-1:0]      angle,
    output logic [31:0]             omega,
    output logic [$clog2(N_CH)-1:0] omega_ch,
    output logic                    omega_valid,
    input  logic                    omega_ready,
    output logic                    sample_tick,
    output logic                    overrun,
    input  logic                    overrun_clr
);
    localparam int CW = $clog2(N_CH);
    localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state, state_nx;
    logic [PERIOD_W-1:0] cnt;
    logic [CW-1:0] ch;
    logic primed;
    logic xfer;
    logic [31:0] snap [N_CH];
    logic [31:0] prev [N_CH];
    // tick decode and handshake qualifier
    always_comb begin
        sample_tick = enable && (cnt >= period);
        xfer = omega_valid && omega_ready;
    end
    // period counter: parked at zero while disabled, restarts on every tick
    always_ff @(posedge clk)
        cnt <= (reset || !enable || sample_tick) ? '0 : cnt + PERIOD_W'(1);
    // state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    // next state: a primed tick starts a round, the last accepted beat ends it
    always_comb begin
        state_nx = state;
        if (state == IDLE && sample_tick && primed)
            state_nx = EMIT;
        else if (state == EMIT && xfer && ch == LAST)
            state_nx = IDLE;
    end
    // outputs: shared subtractor on the current channel, zeroed when not valid
    always_comb begin
        omega_valid = state == EMIT;
        omega_ch = omega_valid ? ch : '0;
        omega = omega_valid ? snap[ch] - prev[ch] : '0;
    end
    // datapath: priming, coherent snapshot, per-channel prev update, sticky overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            primed <= 1'b0;
            ch <= '0;
            overrun <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                snap[k] <= '0;
                prev[k] <= '0;
            end
        end else begin
            if (!enable)
                primed <= 1'b0;
            else if (state == IDLE && sample_tick)
                primed <= 1'b1;
            if (state == IDLE && sample_tick && !primed)
                for (int k = 0; k < N_CH; k++)
                    prev[k] <= angle[32*k +: 32];
            if (state == IDLE && sample_tick && primed) begin
                for (int k = 0; k < N_CH; k++)
                    snap[k] <= angle[32*k +: 32];
                ch <= '0;
            end
            if (xfer) begin
                prev[ch] <= snap[ch];
                if (ch != LAST)
                    ch <= ch + CW'(1);
            end
            overrun <= (sample_tick && state == EMIT) || (overrun && !overrun_clr);
        end
    end
endmodule

// File: tb/tb_speed_sample_scheduler.sv
// tb_speed_sample_scheduler: table, directed and random checks against a queue-based model
module tb_speed_sample_scheduler;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset, enable, omega_valid, omega_ready, sample_tick, overrun, overrun_clr;
    logic [19:0] period;
    logic [127:0] angle;
    logic [31:0] omega;
    logic [1:0] omega_ch;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    speed_sample_scheduler #(.N_CH(N), .PERIOD_W(20)) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period), .angle(angle),
        .omega(omega), .omega_ch(omega_ch), .omega_valid(omega_valid),
        .omega_ready(omega_ready), .sample_tick(sample_tick), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    typedef struct { int ch; logic [31:0] d; } beat_t;
    typedef struct { logic [127:0] a_old, a_new, expv; } vec_t;
    beat_t q[$];
    int mcnt = 0;
    bit mprimed = 0;
    bit movr = 0;
    logic [31:0] base [N];
    logic [31:0] o_omega;
    logic [1:0] o_ch;
    logic o_valid, o_tick, o_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t: event not seen within budget", name, $time);
    endtask

    // one clock: observe and compare against the model, then advance the model
    task automatic step();
        bit tick, busy;
        beat_t bt;
        #1;
        o_omega = omega; o_ch = omega_ch; o_valid = omega_valid; o_tick = sample_tick; o_ovr = overrun;
        busy = q.size() != 0;
        tick = enable && (mcnt >= int'(period));
        chk("sample_tick", 32'(o_tick), 32'(tick));
        chk("omega_valid", 32'(o_valid), 32'(busy));
        chk("omega", o_omega, busy ? q[0].d : 32'd0);
        chk("omega_ch", 32'(o_ch), busy ? 32'(q[0].ch) : 32'd0);
        chk("overrun", 32'(o_ovr), 32'(movr));
        @(posedge clk);
        if (reset) begin
            mcnt = 0; mprimed = 0; movr = 0; q.delete();
            for (int k = 0; k < N; k++) base[k] = '0;
        end else begin
            movr = (tick && busy) || (movr && !overrun_clr);
            if (busy && omega_ready) void'(q.pop_front());
            if (tick && !busy) begin
                for (int k = 0; k < N; k++) begin
                    if (mprimed) begin
                        bt.ch = k;
                        bt.d = angle[32*k +: 32] - base[k];
                        q.push_back(bt);
                    end
                    base[k] = angle[32*k +: 32];
                end
                mprimed = 1;
            end
            if (!enable) mprimed = 0;
            mcnt = (!enable || tick) ? 0 : mcnt + 1;
        end
        @(negedge clk);
    endtask

    // step until a tick is seen while no round is running
    task automatic wait_tick(output int n);
        n = 0;
        while (n < 100) begin
            step();
            n++;
            if (o_tick && !o_valid) return;
        end
        timeout("wait_tick");
    endtask

    task automatic wait_valid(input logic lvl);
        for (int i = 0; i < 60; i++) begin
            step();
            if (o_valid == lvl) return;
        end
        timeout("wait_valid");
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; omega_ready = 1; overrun_clr = 0;
        step();
        reset = 0;
    endtask

    initial begin
        vec_t tbl[3];
        logic [127:0] e, av, bv;
        logic [31:0] so;
        logic [1:0] sc;
        int n;
        for (int k = 0; k < N; k++) base[k] = '0;
        tbl[0] = '{{32'd0, 32'd200, 32'hFFFFFFF0, 32'd100},
                   {32'hFFFFFFFF, 32'd150, 32'h10, 32'd150},
                   {32'hFFFFFFFF, 32'hFFFFFFCE, 32'h20, 32'd50}};
        tbl[1] = '{{32'd1, 32'h7FFFFFFF, 32'd10, 32'd5},
                   {32'd0, 32'h80000000, 32'd9, 32'd5},
                   {32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0}};
        tbl[2] = '{{32'h12345678, 32'd0, 32'd1000, 32'hDEADBEEF},
                   {32'h12345678, 32'hFFFFFFFF, 32'd0, 32'hDEADBEF0},
                   {32'd0, 32'hFFFFFFFF, 32'hFFFFFC18, 32'd1}};
        reset = 1; enable = 0; omega_ready = 1; overrun_clr = 0; period = 9; angle = '0;
        @(posedge clk);
        @(negedge clk);
        // prime then measure, wrap and sign
        for (int i = 0; i < 3; i++) begin
            do_reset();
            period = 9; enable = 1; omega_ready = 1; angle = tbl[i].a_old;
            wait_tick(n);
            angle = tbl[i].a_new;
            step();
            chk("prime_no_valid", 32'(o_valid), 32'd0);
            wait_tick(n);
            chk("tick_spacing", 32'(n + 1), 32'd10);
            e = tbl[i].expv;
            for (int b = 0; b < N; b++) begin
                step();
                chk("tbl_valid", 32'(o_valid), 32'd1);
                chk("tbl_ch", 32'(o_ch), 32'(b));
                chk("tbl_omega", o_omega, e[32*b +: 32]);
            end
            step();
            chk("tbl_idle", 32'(o_valid), 32'd0);
        end
        // backpressure on ch2 with angle changing underneath
        wait_tick(n);
        step();
        step();
        omega_ready = 0;
        step();
        so = o_omega; sc = o_ch;
        chk("bp_ch", 32'(sc), 32'd2);
        angle = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_ch_hold", 32'(o_ch), 32'(sc));
            chk("bp_omega_hold", o_omega, so);
        end
        omega_ready = 1;
        step();
        step();
        chk("bp_ch3", 32'(o_ch), 32'd3);
        // overrun and a delta spanning the dropped interval
        period = 2;
        av = {$urandom, $urandom, $urandom, $urandom};
        bv = {$urandom, $urandom, $urandom, $urandom};
        angle = av;
        wait_tick(n);
        omega_ready = 0; angle = bv;
        for (int i = 0; i < 10; i++) step();
        chk("overrun_set", 32'(o_ovr), 32'd1);
        omega_ready = 1;
        wait_valid(1'b0);
        wait_valid(1'b1);
        chk("span_delta", o_omega, bv[31:0] - av[31:0]);
        // clear, then clear coinciding with a dropped tick
        wait_tick(n);
        omega_ready = 0; overrun_clr = 1;
        step();
        step();
        chk("overrun_cleared", 32'(o_ovr), 32'd0);
        step();
        chk("clr_tick_overlap", 32'(o_tick && o_valid), 32'd1);
        overrun_clr = 0;
        step();
        chk("set_wins", 32'(o_ovr), 32'd1);
        omega_ready = 1;
        wait_valid(1'b0);
        // enable drop mid-round
        period = 9;
        wait_tick(n);
        step();
        enable = 0;
        for (int i = 0; i < 7; i++) step();
        chk("round_done", 32'(o_valid), 32'd0);
        enable = 1;
        wait_tick(n);
        chk("reenable_spacing", 32'(n), 32'd10);
        step();
        chk("reenable_prime_only", 32'(o_valid), 32'd0);
        wait_tick(n);
        step();
        chk("round_after_prime", 32'(o_valid), 32'd1);
        // reset mid-round
        step();
        reset = 1;
        step();
        reset = 0;
        step();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_omega", o_omega, 32'd0);
        chk("rst_ovr", 32'(o_ovr), 32'd0);
        // period zero
        do_reset();
        period = 0; enable = 1; omega_ready = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("p0_tick", 32'(o_tick), 32'd1);
        end
        chk("p0_overrun", 32'(o_ovr), 32'd1);
        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 299) == 0;
            if ($urandom_range(0, 49) == 0) enable = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 29) == 0) period = 20'($urandom_range(0, 7));
            omega_ready = $urandom_range(0, 3) != 0;
            overrun_clr = $urandom_range(0, 9) == 0;
            for (int k = 0; k < N; k++)
                angle[32*k +: 32] = $urandom_range(0, 1) ? $urandom : angle[32*k +: 32] + 32'($urandom_range(0, 40)) - 32'd20;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/speed_sample_scheduler.md
# speed_sample_scheduler

Time-multiplexed controller for wheel/odometer speed measurement. It generates the programmable sample tick and captures all encoder angles coherently on the same cycle. One 32-bit subtractor is then shared across channels in round-robin order, and each per-channel delta (omega) is presented on a single valid/ready stream. It sits between the encoder counters and the register/SPI readout.

## Interface
- N_CH, default 4: number of angle channels (2..8).
- PERIOD_W, default 20: width of the sample-period register.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sampling enable.
- period  in  PERIOD_W  sample interval minus one, in clk cycles; ticks every period+1 cycles.
- angle  in  N_CH*32  packed encoder angles; channel k is bits [32k+31:32k].
- omega  out  32  angle delta of channel omega_ch (two's complement, mod 2^32).
- omega_ch  out  $clog2(N_CH)  channel index of current omega.
- omega_valid  out  1  omega/omega_ch valid.
- omega_ready  in  1  consumer accepts the current word.
- sample_tick  out  1  one-cycle pulse on every period expiry.
- overrun  out  1  sticky: a tick arrived before the previous round finished.
- overrun_clr  in  1  clears overrun.

## Operation
- Period counter cnt (PERIOD_W bits):
  - enable=0: cnt held at 0.
  - Otherwise cnt increments; when cnt >= period, sample_tick=1 and cnt<=0 next cycle.
  - period=0 gives a tick every cycle.
  - period is compared live; a change takes effect immediately.
- Storage:
  - snap[N_CH] and prev[N_CH], 32 bits each.
  - primed flag, 1 bit.
- FSM states IDLE and EMIT.
  - IDLE, tick, primed=0: prev[k]<=angle[k] for all k, primed<=1, stay in IDLE, no output.
  - IDLE, tick, primed=1: snap[k]<=angle[k] for all k, ch<=0, go to EMIT.
  - EMIT: omega_valid=1, omega=snap[ch]-prev[ch], omega_ch=ch.
    - On omega_valid&&omega_ready: prev[ch]<=snap[ch].
    - If ch==N_CH-1, go to IDLE; else ch<=ch+1.
  - Tick while in EMIT: no snapshot and no state change; overrun<=1. That tick's sample is dropped. prev is unchanged, so the next delta spans the missed interval.
- Arithmetic: plain 32-bit subtraction, with wrap-around modulo 2^32 and no saturation.
  - Example: 0x00000010-0xFFFFFFF0 = 0x00000020.
  - Example: 150-200 = 0xFFFFFFCE.
- overrun:
  - Set by a dropped tick.
  - Cleared by overrun_clr.
  - Set and clear in the same cycle: set wins.
- enable falling:
  - A round in progress completes normally.
  - primed<=0, so the first tick after re-enable only primes.
- omega and omega_ch are forced to 0 when omega_valid=0.

## Timing
- Reset values:
  - Outputs: omega=0, omega_ch=0, omega_valid=0, sample_tick=0, overrun=0.
  - Internal: cnt=0, state=IDLE, primed=0, all snap and prev=0.
- Reset mid-round aborts immediately: valid drops the next cycle and all state is cleared.
- Tick in cycle t (primed, IDLE):
  - angle is captured at the edge ending cycle t.
  - omega_valid=1 for ch0 from cycle t+1.
- With omega_ready held high, the round occupies cycles t+1..t+N_CH, one channel per cycle. omega_valid is low in cycle t+N_CH+1.
- A tick in cycle t+N_CH (last beat, handshake completing) counts as an overrun, because state is still EMIT.
- A tick at t+N_CH+1 or later starts a new round.
- Backpressure: while omega_valid&&!omega_ready, omega, omega_ch and snap are held stable. Throughput is unaffected apart from the overrun rule.
- omega_valid never deasserts without a handshake, except under reset.
- sample_tick is a combinational decode of the registered cnt and period. All other outputs come from registers or registered state.

## Test plan
- Prime then measure:
  - Stimulus: N_CH=4, period=9, ready=1; ch0 angle=100 at the first tick, 150 at the second.
  - Response: no valid after the first tick. After the second, omega=50, omega_ch=0 one cycle after the tick, then ch1..3 on consecutive cycles. Ticks are 10 cycles apart.
- Wrap and sign:
  - Stimulus: ch1 goes 0xFFFFFFF0 -> 0x00000010; ch2 goes 200 -> 150.
  - Response: omega 0x00000020 and 0xFFFFFFCE respectively.
- Backpressure:
  - Stimulus: hold omega_ready=0 for 5 cycles on ch2, and change angle meanwhile.
  - Response: valid stays high; omega and omega_ch are stable and equal to the captured delta; order is 0,1,2,3.
- Overrun:
  - Stimulus: period=2, ready=0 for 10 cycles.
  - Response: overrun=1 after the first tick inside EMIT, and the next round's delta spans both intervals. Pulsing overrun_clr clears it; overrun_clr on the same cycle as a dropped tick leaves overrun=1.
- Enable and reset:
  - Stimulus: drop enable mid-round.
  - Response: round completes, cnt held at 0, and the next tick after re-enable only primes.
  - Stimulus: assert reset mid-round.
  - Response: valid=0 the next cycle, and all outputs are at reset values.
- period=0:
  - Stimulus: period=0 with ready=1.
  - Response: sample_tick every cycle and overrun set during the first round.
